// File: rtl/line_window_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : line_window_gen_if
// Description : Pixel stream in / 3x3 window stream out bundle for
//               line_window_gen.
//   i_pixel_data        [7:0]  incoming raster-order pixel
//   i_pixel_data_valid         i_pixel_data presented this cycle
//   o_pixel_data        [71:0] 3x3 window, byte k = row k/3, col k%3
//   o_pixel_data_valid         o_pixel_data holds a fresh window
//   o_intr                     one line buffer released (one-cycle pulse)
//   o_overflow                 sticky: an input pixel was dropped
//   modport slave  : window generator side
//   modport master : pixel source / window sink side
// Revision    : 1.0 - initial release
// ============================================================================
interface line_window_gen_if;
    logic [7:0]  i_pixel_data;
    logic        i_pixel_data_valid;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_intr;
    logic        o_overflow;

    modport slave (
        input  i_pixel_data,
        input  i_pixel_data_valid,
        output o_pixel_data,
        output o_pixel_data_valid,
        output o_intr,
        output o_overflow
    );

    modport master (
        output i_pixel_data,
        output i_pixel_data_valid,
        input  o_pixel_data,
        input  o_pixel_data_valid,
        input  o_intr,
        input  o_overflow
    );
endinterface
`default_nettype wire

// File: rtl/line_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : line_window_gen
// Description : Buffers four image lines and emits one 3x3 pixel window per
//               cycle for each column once three full lines are stored.
//               Columns past the right edge replicate the last column.
//   i_clk   : clock, rising edge
//   i_rstn  : asynchronous active-low reset
//   bus     : line_window_gen_if.slave (pixel in, window out, intr, overflow)
//   LINE_WIDTH : pixels per line (>= 4)
// Revision    : 1.0 - initial release
// ============================================================================
module line_window_gen #(
    parameter int LINE_WIDTH = 512
) (
    input  wire              i_clk,
    input  wire              i_rstn,
    line_window_gen_if.slave bus
);

    localparam int c_COL_W = $clog2(LINE_WIDTH);
    localparam int c_CNT_W = $clog2(4 * LINE_WIDTH + 1);
    localparam logic [c_COL_W-1:0] c_LAST_COL  = c_COL_W'(LINE_WIDTH - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL  = c_CNT_W'(4 * LINE_WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_START = c_CNT_W'(3 * LINE_WIDTH);
    localparam logic [c_CNT_W-1:0] c_CNT_LINE  = c_CNT_W'(LINE_WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RD   = 1'b1
    } state_t;

    // Line storage; contents intentionally have no reset.
    logic [7:0]          r_lb [0:3][0:LINE_WIDTH-1];

    logic [1:0]          r_wr_lb;
    logic [c_COL_W-1:0]  r_wr_col;
    logic [c_CNT_W-1:0]  r_pix_cnt;
    logic [c_CNT_W-1:0]  w_pix_cnt_nxt;
    logic [1:0]          r_rd_lb;
    logic [c_COL_W-1:0]  r_rd_col;
    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_rd_active;
    logic                w_release;
    logic                w_full;
    logic                w_accept;
    logic                w_drop;

    logic [71:0]         w_window;
    logic [1:0]          w_row [0:2];
    logic [c_COL_W:0]    w_col_ext [0:2];
    logic [c_COL_W-1:0]  w_col [0:2];

    logic [71:0]         r_pixel_data;
    logic                r_pixel_data_valid;
    logic                r_intr;
    logic                r_overflow;

    // ------------------------------------------------------------------
    // Write side. A release on the same edge frees a line, so a pixel
    // arriving while all four buffers are full is still accepted then.
    // ------------------------------------------------------------------
    assign w_full   = (r_pix_cnt == c_CNT_FULL);
    assign w_accept = bus.i_pixel_data_valid && (!w_full || w_release);
    assign w_drop   = bus.i_pixel_data_valid && w_full && !w_release;

    always_comb begin
        w_pix_cnt_nxt = r_pix_cnt;
        unique case ({w_accept, w_release})
            2'b10:   w_pix_cnt_nxt = r_pix_cnt + c_CNT_W'(1);
            2'b01:   w_pix_cnt_nxt = r_pix_cnt - c_CNT_LINE;
            2'b11:   w_pix_cnt_nxt = r_pix_cnt + c_CNT_W'(1) - c_CNT_LINE;
            default: w_pix_cnt_nxt = r_pix_cnt;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (w_accept) begin
            r_lb[r_wr_lb][r_wr_col] <= bus.i_pixel_data;
        end
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_lb   <= '0;
            r_wr_col  <= '0;
            r_pix_cnt <= '0;
        end else begin
            if (w_accept) begin
                if (r_wr_col == c_LAST_COL) begin
                    r_wr_col <= '0;
                    r_wr_lb  <= r_wr_lb + 2'd1;
                end else begin
                    r_wr_col <= r_wr_col + c_COL_W'(1);
                end
            end
            r_pix_cnt <= w_pix_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Read FSM: IDLE waits for three buffered lines, RD sweeps one line
    // of columns without stalling, then returns to IDLE for one cycle.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_rd_active = 1'b0;
        w_release   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (r_pix_cnt >= c_CNT_START) begin
                    w_state_nxt = ST_RD;
                end
            end
            ST_RD: begin
                w_rd_active = 1'b1;
                if (r_rd_col == c_LAST_COL) begin
                    w_release   = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_rd_lb  <= '0;
            r_rd_col <= '0;
        end else if (w_rd_active) begin
            if (w_release) begin
                r_rd_col <= '0;
                r_rd_lb  <= r_rd_lb + 2'd1;
            end else begin
                r_rd_col <= r_rd_col + c_COL_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Window gather: rows wrap modulo four buffers, columns past the
    // right edge clamp to the last column.
    // ------------------------------------------------------------------
    for (genvar g_i = 0; g_i < 3; g_i++) begin : g_idx
        assign w_row[g_i]     = r_rd_lb + 2'(g_i);
        assign w_col_ext[g_i] = {1'b0, r_rd_col} + (c_COL_W + 1)'(g_i);
        assign w_col[g_i]     = (w_col_ext[g_i] >= (c_COL_W + 1)'(LINE_WIDTH))
                                ? c_LAST_COL : w_col_ext[g_i][c_COL_W-1:0];
    end

    for (genvar g_r = 0; g_r < 3; g_r++) begin : g_win_row
        for (genvar g_c = 0; g_c < 3; g_c++) begin : g_win_col
            assign w_window[(g_r*3 + g_c)*8 +: 8] = r_lb[w_row[g_r]][w_col[g_c]];
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs; window data holds when no window is read.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_pixel_data       <= '0;
            r_pixel_data_valid <= 1'b0;
            r_intr             <= 1'b0;
            r_overflow         <= 1'b0;
        end else begin
            r_pixel_data_valid <= w_rd_active;
            r_intr             <= w_release;
            if (w_rd_active) begin
                r_pixel_data <= w_window;
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.o_pixel_data       = r_pixel_data;
    assign bus.o_pixel_data_valid = r_pixel_data_valid;
    assign bus.o_intr             = r_intr;
    assign bus.o_overflow         = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_line_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_window_gen
// Description : Self-checking bench for line_window_gen (LINE_WIDTH = 8).
//               Stimulus pushes expected windows into a queue; a monitor
//               pops and compares every valid window it sees.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_window_gen;

    localparam int LW = 8;

    typedef struct packed {
        logic [71:0] data;
        logic        intr;
    } exp_t;

    logic clk;
    logic rstn;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   n_windows = 0;
    exp_t q[$];

    line_window_gen_if bus ();

    line_window_gen #(.LINE_WIDTH(LW)) dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    function automatic logic [7:0] pix(input int k);
        return 8'(((k / LW) * 16) + (k % LW));
    endfunction

    // Expected window from the known image: pixel (line, col) = base + line*16 + col.
    function automatic logic [71:0] exp_win(input int top, input int col, input logic [7:0] base);
        logic [71:0] w;
        int c;
        w = '0;
        for (int k = 0; k < 9; k++) begin
            c = col + (k % 3);
            if (c > LW - 1) c = LW - 1;
            w[k*8 +: 8] = base + 8'(((top + k / 3) * 16) + c);
        end
        return w;
    endfunction

    task automatic push_win(input int top, input int col, input logic [7:0] base);
        q.push_back({exp_win(top, col, base), (col == LW - 1)});
    endtask

    task automatic push_run(input int top, input logic [7:0] base);
        for (int c = 0; c < LW; c++) push_win(top, c, base);
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        bus.i_pixel_data_valid = v;
        bus.i_pixel_data       = d;
        @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rstn = 1'b0;
        bus.i_pixel_data_valid = 1'b0;
        repeat (n) @(negedge clk);
        rstn = 1'b1;
    endtask

    // Monitor: every valid window must match the head of the queue.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (bus.o_pixel_data_valid) begin
                    n_windows++;
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_window: actual %h required none", bus.o_pixel_data);
                    end else begin
                        e = q.pop_front();
                        chk("window_data", bus.o_pixel_data, e.data);
                        chk("window_intr", 72'(bus.o_intr), 72'(e.intr));
                    end
                end else if (bus.o_intr) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL intr_without_window: actual 1 required 0");
                end
            end
        end
    end

    initial begin
        int w0;
        logic exp_v;

        // ---------------- reset held with valid input ----------------
        rstn = 1'b0;
        bus.i_pixel_data_valid = 1'b1;
        bus.i_pixel_data       = 8'hAA;
        #1;
        chk("rst_async_valid", 72'(bus.o_pixel_data_valid), 72'd0);
        chk("rst_async_data",  bus.o_pixel_data, 72'd0);
        chk("rst_async_intr",  72'(bus.o_intr), 72'd0);
        chk("rst_async_ovf",   72'(bus.o_overflow), 72'd0);
        repeat (3) @(negedge clk);
        chk("rst_hold_valid", 72'(bus.o_pixel_data_valid), 72'd0);
        chk("rst_hold_ovf",   72'(bus.o_overflow), 72'd0);
        rstn = 1'b1;

        // ---------------- first RD run, idle after 24 pixels ----------------
        w0 = n_windows;
        for (int k = 0; k < 23; k++) drive(1'b1, pix(k));
        repeat (5) drive(1'b0, 8'h00);
        chk("no_window_before_24", 72'(n_windows - w0), 72'd0);

        q.push_back({72'h22_21_20_12_11_10_02_01_00, 1'b0});
        for (int c = 1; c < LW - 1; c++) push_win(0, c, 8'h00);
        q.push_back({72'h27_27_27_17_17_17_07_07_07, 1'b1});

        drive(1'b1, pix(23));
        chk("first_lat_e0", 72'(bus.o_pixel_data_valid), 72'd0);
        drive(1'b0, 8'h00);
        chk("first_lat_e1", 72'(bus.o_pixel_data_valid), 72'd0);
        drive(1'b0, 8'h00);
        chk("first_lat_e2", 72'(bus.o_pixel_data_valid), 72'd1);
        repeat (6) drive(1'b0, 8'h00);
        chk("intr_before_last", 72'(bus.o_intr), 72'd0);
        drive(1'b0, 8'h00);
        chk("intr_last", 72'(bus.o_intr), 72'd1);
        drive(1'b0, 8'h00);
        chk("intr_after_last", 72'(bus.o_intr), 72'd0);
        chk("valid_after_last", 72'(bus.o_pixel_data_valid), 72'd0);
        chk("data_hold", bus.o_pixel_data, 72'h27_27_27_17_17_17_07_07_07);
        repeat (3) drive(1'b0, 8'h00);
        chk("runA_queue_empty", 72'(q.size()), 72'd0);
        chk("runA_window_count", 72'(n_windows - w0), 72'd8);

        // ---------------- 4th line written during first RD run ----------------
        do_reset(2);
        w0 = n_windows;
        push_run(0, 8'h00);
        q.push_back({72'h32_31_30_22_21_20_12_11_10, 1'b0});
        for (int c = 1; c < LW; c++) push_win(1, c, 8'h00);
        for (int k = 1; k <= 45; k++) begin
            drive(k <= 32, pix(k - 1));
            exp_v = ((k >= 26) && (k <= 33)) || ((k >= 35) && (k <= 42));
            chk("valid_pattern_B", 72'(bus.o_pixel_data_valid), 72'(exp_v));
        end
        chk("runB_queue_empty", 72'(q.size()), 72'd0);
        chk("runB_window_count", 72'(n_windows - w0), 72'd16);

        // ---------------- continuous input, overflow ----------------
        do_reset(2);
        w0 = n_windows;
        push_run(0, 8'h00);
        push_run(1, 8'h00);
        push_run(2, 8'h00);   // line 4 col 0 (pixel 33) must be present
        for (int k = 1; k <= 56; k++) begin
            drive(k <= 48, pix(k - 1));
            if (k == 40) chk("ovf_before_drop", 72'(bus.o_overflow), 72'd0);
            if (k == 41) chk("ovf_at_drop", 72'(bus.o_overflow), 72'd1);
        end
        chk("ovf_sticky", 72'(bus.o_overflow), 72'd1);
        chk("runC_queue_empty", 72'(q.size()), 72'd0);
        chk("runC_window_count", 72'(n_windows - w0), 72'd24);

        // ---------------- reset during RD ----------------
        do_reset(2);
        chk("ovf_cleared", 72'(bus.o_overflow), 72'd0);
        w0 = n_windows;
        for (int c = 0; c < 3; c++) q.push_back({exp_win(0, c, 8'h00), 1'b0});
        for (int k = 0; k < 24; k++) drive(1'b1, pix(k));
        repeat (4) drive(1'b0, 8'h00);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrd_rst_valid", 72'(bus.o_pixel_data_valid), 72'd0);
        chk("midrd_rst_data",  bus.o_pixel_data, 72'd0);
        chk("midrd_rst_intr",  72'(bus.o_intr), 72'd0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        chk("runD_partial_count", 72'(n_windows - w0), 72'd3);
        chk("runD_partial_queue", 72'(q.size()), 72'd0);

        w0 = n_windows;
        push_run(0, 8'h80);
        for (int k = 0; k < 24; k++) drive(1'b1, 8'h80 + pix(k));
        repeat (12) drive(1'b0, 8'h00);
        chk("runD_queue_empty", 72'(q.size()), 72'd0);
        chk("runD_window_count", 72'(n_windows - w0), 72'd8);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
